// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform and recovers the generator
// settings (period, high time, duty in eighths, 2-bit frequency code).
//
// Optional build macro: PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample majority
// filter after the synchronizer. It rejects single-cycle glitches and delays
// edges by one extra cycle.
//
// Ports:
//   Clk         clock
//   Rst         asynchronous active-low reset
//   En          measurement enable (0 forces IDLE, outputs hold)
//   PwmIn       asynchronous PWM input
//   Period      cycles between consecutive rising edges
//   HighTime    cycles high within that period
//   DutyEighths round(8*HighTime/Period), 0..8
//   FreqCode    nearest frequency code
//   Valid       one-cycle pulse when all results update
//   Stuck       no edge seen for TIMEOUT_CYCLES
//   StuckLevel  input level when Stuck was set
module pwm_capture #(
    parameter int unsigned COUNTER_BITS   = 32,
    parameter int unsigned InternalClock  = 25000000,
    parameter int unsigned Freq           = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 4 * InternalClock / Freq
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    En,
    input  logic                    PwmIn,
    output logic [COUNTER_BITS-1:0] Period,
    output logic [COUNTER_BITS-1:0] HighTime,
    output logic [3:0]              DutyEighths,
    output logic [1:0]              FreqCode,
    output logic                    Valid,
    output logic                    Stuck,
    output logic                    StuckLevel
);

    localparam int unsigned CW = COUNTER_BITS + 4;

    // Expected generator periods per code and the midpoints between them.
    localparam int unsigned P0 = InternalClock / (1 * Freq) + 1;
    localparam int unsigned P1 = InternalClock / (2 * Freq) + 1;
    localparam int unsigned P2 = InternalClock / (3 * Freq) + 1;
    localparam int unsigned P3 = InternalClock / (4 * Freq) + 1;
    localparam int unsigned M0 = (P0 + P1) / 2;
    localparam int unsigned M1 = (P1 + P2) / 2;
    localparam int unsigned M2 = (P2 + P3) / 2;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic sync1, sync2, s, s_d;
    logic rise, fall;

    // Two-flop synchronizer.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= PwmIn;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic hist1, hist2;

    // Sample history for the majority vote.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hist1 <= 1'b0;
            hist2 <= 1'b0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
        end
    end

    // Level changes only once two of the last three samples agree.
    assign s = (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
`else
    assign s = sync2;
`endif

    // Edge detector.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) s_d <= 1'b0;
        else      s_d <= s;
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    state_t                  state;
    logic [COUNTER_BITS-1:0] cnt;
    logic [COUNTER_BITS-1:0] hi_cnt;    // high time of the measurement in progress
    logic [COUNTER_BITS-1:0] hi_lat;    // high time of the period being divided
    logic [COUNTER_BITS-1:0] per_cnt;   // period being divided (divisor)
    logic [CW-1:0]           rem;
    logic [3:0]              quo;
    logic [2:0]              calc_step; // 4..1 = iteration in progress, 0 = idle

    logic [1:0]    step_i;
    logic [CW-1:0] shifted;
    logic          rem_ge;
    logic [CW-1:0] rem_nxt;
    logic [3:0]    quo_nxt;
    logic [1:0]    freq_code_c;
    logic          calc_busy;
    logic          timeout;

    // One restoring-divide iteration plus the frequency classification.
    always_comb begin
        step_i      = 2'(calc_step - 3'd1);
        shifted     = CW'(per_cnt) << step_i;
        rem_ge      = (rem >= shifted);
        rem_nxt     = rem_ge ? (rem - shifted) : rem;
        quo_nxt     = quo | (4'(rem_ge) << step_i);
        freq_code_c = 2'd3;
        if (per_cnt >= COUNTER_BITS'(M0))      freq_code_c = 2'd0;
        else if (per_cnt >= COUNTER_BITS'(M1)) freq_code_c = 2'd1;
        else if (per_cnt >= COUNTER_BITS'(M2)) freq_code_c = 2'd2;
    end

    // The publishing cycle still counts as busy so a period under 6 cycles is dropped.
    assign calc_busy = (calc_step != 3'd0) || Valid;
    assign timeout   = (cnt == COUNTER_BITS'(TIMEOUT_CYCLES));

    // Measurement FSM and divider sequencer.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hi_cnt      <= '0;
            hi_lat      <= '0;
            per_cnt     <= '0;
            rem         <= '0;
            quo         <= '0;
            calc_step   <= 3'd0;
            Period      <= '0;
            HighTime    <= '0;
            DutyEighths <= '0;
            FreqCode    <= '0;
            Valid       <= 1'b0;
            Stuck       <= 1'b0;
            StuckLevel  <= 1'b0;
        end else begin
            Valid <= 1'b0;
            if (!En) begin
                state     <= IDLE;
                cnt       <= '0;
                calc_step <= 3'd0;
            end else begin
                if (calc_step != 3'd0) begin
                    rem       <= rem_nxt;
                    quo       <= quo_nxt;
                    calc_step <= calc_step - 3'd1;
                    // Last iteration is folded into the publish cycle.
                    if (calc_step == 3'd1) begin
                        Period      <= per_cnt;
                        HighTime    <= hi_lat;
                        DutyEighths <= quo_nxt;
                        FreqCode    <= freq_code_c;
                        Valid       <= 1'b1;
                        Stuck       <= 1'b0;
                    end
                end

                case (state)
                    IDLE: begin
                        if (rise) begin
                            cnt   <= COUNTER_BITS'(1);  // edge cycle is part of the high time
                            state <= HIGH;
                        end else if (fall) begin
                            cnt <= '0;
                        end else if (timeout) begin
                            Stuck      <= 1'b1;
                            StuckLevel <= s;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + COUNTER_BITS'(1);
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            hi_cnt <= cnt;
                            cnt    <= cnt + COUNTER_BITS'(1);
                            state  <= LOW;
                        end else if (timeout) begin
                            Stuck      <= 1'b1;
                            StuckLevel <= s;
                            cnt        <= '0;
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt + COUNTER_BITS'(1);
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            cnt   <= COUNTER_BITS'(1);
                            state <= HIGH;
                            if (!calc_busy) begin
                                per_cnt   <= cnt;
                                hi_lat    <= hi_cnt;
                                // N = 8*H + P/2 gives round-to-nearest.
                                rem       <= (CW'(hi_cnt) << 3) + CW'(cnt >> 1);
                                quo       <= 4'd0;
                                calc_step <= 3'd4;
                            end
                        end else if (timeout) begin
                            Stuck      <= 1'b1;
                            StuckLevel <= s;
                            cnt        <= '0;
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt + COUNTER_BITS'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes hand-computed results,
// a monitor pops and compares on every Valid pulse.
module tb_pwm_capture;

    localparam int unsigned CB = 32;
    localparam int unsigned TO = 10000;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int unsigned LX = 1;
`else
    localparam int unsigned LX = 0;
`endif

    logic          Clk = 1'b0;
    logic          Rst;
    logic          En;
    logic          PwmIn;
    logic [CB-1:0] Period;
    logic [CB-1:0] HighTime;
    logic [3:0]    DutyEighths;
    logic [1:0]    FreqCode;
    logic          Valid;
    logic          Stuck;
    logic          StuckLevel;

    pwm_capture dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .En         (En),
        .PwmIn      (PwmIn),
        .Period     (Period),
        .HighTime   (HighTime),
        .DutyEighths(DutyEighths),
        .FreqCode   (FreqCode),
        .Valid      (Valid),
        .Stuck      (Stuck),
        .StuckLevel (StuckLevel)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned per;
        int unsigned hi;
        int unsigned duty;
        int unsigned code;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   n_valid  = 0;
    int   n_pushed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic push(input int unsigned per, input int unsigned hi,
                        input int unsigned duty, input int unsigned code);
        exp_t e;
        e.per  = per;
        e.hi   = hi;
        e.duty = duty;
        e.code = code;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Hold PwmIn at lvl for cyc clocks; always leaves time at posedge+1.
    task automatic drive(input logic lvl, input int unsigned cyc);
        PwmIn = lvl;
        repeat (cyc) @(posedge Clk);
        #1;
    endtask

    // Drop En briefly so the FSM starts the next block from IDLE.
    task automatic separator();
        drive(1'b0, 10);
        En = 1'b0;
        drive(1'b0, 20);
        En = 1'b1;
        drive(1'b0, 5);
    endtask

    // n full periods plus a closing rising edge: n Valid pulses expected.
    task automatic run_pwm(input int unsigned hi, input int unsigned per, input int unsigned n,
                           input int unsigned duty, input int unsigned code);
        for (int i = 0; i < int'(n); i++) begin
            push(per, hi, duty, code);
            drive(1'b1, hi);
            drive(1'b0, per - hi);
        end
        drive(1'b1, hi);
        separator();
    endtask

    // Monitor: every Valid consumes one expectation.
    always @(negedge Clk) begin
        if (Rst === 1'b1 && Valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got Valid with Period=%0d HighTime=%0d, expected no Valid (t=%0t)",
                         Period, HighTime, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_period",   64'(Period),      64'(e.per));
                check("valid_hightime", 64'(HighTime),    64'(e.hi));
                check("valid_duty",     64'(DutyEighths), 64'(e.duty));
                check("valid_freqcode", 64'(FreqCode),    64'(e.code));
                check("valid_stuck",    64'(Stuck),       64'(0));
            end
        end
    end

    initial begin
        Rst   = 1'b0;
        En    = 1'b0;
        PwmIn = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        check("rst_period",     64'(Period),      64'(0));
        check("rst_hightime",   64'(HighTime),    64'(0));
        check("rst_duty",       64'(DutyEighths), 64'(0));
        check("rst_freqcode",   64'(FreqCode),    64'(0));
        check("rst_valid",      64'(Valid),       64'(0));
        check("rst_stuck",      64'(Stuck),       64'(0));
        check("rst_stucklevel", 64'(StuckLevel),  64'(0));
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        En = 1'b1;
        drive(1'b0, 5);

        // Generator-shaped waveform, three high pulses.
        run_pwm(937, 2501, 2, 3, 0);

        // Duty and frequency-code boundaries.
        run_pwm(313, 626, 2, 4, 3);
        run_pwm(521, 1042, 1, 4, 1);
        run_pwm(520, 1041, 1, 4, 2);
        run_pwm(235, 1876, 1, 1, 0);
        run_pwm(235, 1875, 1, 1, 1);

        // Input held high after a measurement.
        push(2501, 937, 3, 0);
        drive(1'b1, 937);
        drive(1'b0, 1564);
        PwmIn = 1'b1;
        repeat (TO + 2 + LX) @(posedge Clk);
        @(negedge Clk);
        check("stuck_early", 64'(Stuck), 64'(0));
        @(posedge Clk);
        @(negedge Clk);
        check("stuck_set",      64'(Stuck),       64'(1));
        check("stuck_level",    64'(StuckLevel),  64'(1));
        check("stuck_period",   64'(Period),      64'(2501));
        check("stuck_hightime", 64'(HighTime),    64'(937));
        check("stuck_duty",     64'(DutyEighths), 64'(3));
        check("stuck_freqcode", 64'(FreqCode),    64'(0));
        @(posedge Clk);
        #1;
        drive(1'b0, 20);
        run_pwm(937, 2501, 1, 3, 0);
        check("stuck_cleared", 64'(Stuck), 64'(0));

        // En dropped mid-HIGH: interrupted period is never published.
        drive(1'b1, 300);
        En = 1'b0;
        drive(1'b1, 100);
        En = 1'b1;
        drive(1'b1, 537);
        drive(1'b0, 1564);
        run_pwm(937, 2501, 1, 3, 0);

        // One-cycle low glitch in the middle of the high phase.
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        push(2501, 937, 3, 0);
`else
        push(401, 400, 8, 3);
        push(2100, 536, 2, 0);
`endif
        drive(1'b1, 400);
        drive(1'b0, 1);
        drive(1'b1, 536);
        drive(1'b0, 1564);
        drive(1'b1, 937);
        separator();

        // Reset two cycles into CALC: outputs clear, no Valid follows.
        drive(1'b1, 313);
        drive(1'b0, 313);
        PwmIn = 1'b1;
        repeat (5 + LX) @(posedge Clk);
        #1;
        Rst = 1'b0;
        #1;
        check("midcalc_period",     64'(Period),      64'(0));
        check("midcalc_hightime",   64'(HighTime),    64'(0));
        check("midcalc_duty",       64'(DutyEighths), 64'(0));
        check("midcalc_freqcode",   64'(FreqCode),    64'(0));
        check("midcalc_valid",      64'(Valid),       64'(0));
        check("midcalc_stuck",      64'(Stuck),       64'(0));
        check("midcalc_stucklevel", 64'(StuckLevel),  64'(0));
        PwmIn = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;
        drive(1'b0, 20);
        run_pwm(313, 626, 1, 4, 3);

        drive(1'b0, 20);
        check("pending_expectations", 64'(exp_q.size()), 64'(0));
        check("valid_count",          64'(n_valid),      64'(n_pushed));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
